// File: rtl/sqrt_share_arbiter.sv
// sqrt_share_arbiter
//   Shares one bit-serial restoring integer square-root engine among NREQ
//   requesters. A round-robin arbiter picks one pending requester while the
//   engine is idle, captures its operand, computes floor(sqrt(operand)) one
//   root bit per cycle, and returns the root with the requester index over a
//   valid/ready response channel. Only one operation is in flight at a time.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   req        per-requester "operand pending" flags
//   req_data   packed operands, operand k at [k*DATA_W +: DATA_W]
//   gnt        registered one-hot pulse, one cycle, marking operand capture
//   busy       high while computing or holding a response
//   rsp_valid  result available on rsp_root/rsp_id
//   rsp_ready  consumer accepts the result
//   rsp_id     index of the requester that owns the current result
//   rsp_root   floor(sqrt(operand))

module sqrt_share_arbiter #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 29,
  parameter int IDW    = 3,
  localparam int ROOT_W = (DATA_W + 1) / 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          gnt,
  output logic                     busy,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [ROOT_W-1:0]        rsp_root
);

  // The operand is zero-extended to an even width so it splits into bit pairs.
  localparam int OP_W  = 2 * ROOT_W;
  localparam int REM_W = ROOT_W + 2;
  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(ROOT_W + 1);

  if (NREQ < 2 || NREQ > 8 || DATA_W < 2 || (1 << IDW) < NREQ) begin : g_param_check
    $error("sqrt_share_arbiter: invalid parameter combination");
  end

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t            state;
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  id_q;
  logic [OP_W-1:0]   op;
  logic [REM_W-1:0]  rem;
  logic [ROOT_W-1:0] root;
  logic [CNT_W-1:0]  counter;
  logic              drain;

  logic              found;
  logic [PTR_W-1:0]  winner;
  logic [PTR_W-1:0]  next_ptr;

  logic [REM_W+1:0]  trial_in;
  logic [REM_W+1:0]  trial_sub;
  logic [REM_W+1:0]  trial;
  logic              take;
  logic [REM_W-1:0]  rem_next;
  logic [ROOT_W-1:0] root_next;

  // Round-robin search: first set req bit at or above rr_ptr, wrapping to 0.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[(int'(rr_ptr) + i) % NREQ]) begin
        found  = 1'b1;
        winner = PTR_W'((int'(rr_ptr) + i) % NREQ);
      end
    end
    next_ptr = (int'(winner) == NREQ - 1) ? '0 : winner + 1'b1;
  end

  // One restoring step: bring down the next two operand bits and try to
  // subtract (root<<2 | 1). The remainder never exceeds 2*root, so after the
  // compare it always fits REM_W bits and the truncation is lossless.
  always_comb begin
    trial_in  = {rem, op[OP_W-1 -: 2]};
    trial_sub = {2'b00, root, 2'b01};
    take      = (trial_in >= trial_sub);
    trial     = trial_in - trial_sub;
    rem_next  = take ? trial[REM_W-1:0] : trial_in[REM_W-1:0];
    root_next = ROOT_W'({root, take});
  end

  // Control FSM and datapath registers. ROOT_W iterations run while counter
  // walks from ROOT_W-1 down to 0; the extra drain cycle afterwards moves the
  // finished root into the response registers, giving a capture-to-valid
  // distance of ROOT_W+1 edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      id_q      <= '0;
      op        <= '0;
      rem       <= '0;
      root      <= '0;
      counter   <= '0;
      drain     <= 1'b0;
      gnt       <= '0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_root  <= '0;
    end else begin
      gnt <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            op      <= OP_W'(req_data[int'(winner)*DATA_W +: DATA_W]);
            id_q    <= winner;
            gnt     <= NREQ'(1) << winner;
            rr_ptr  <= next_ptr;
            counter <= CNT_W'(ROOT_W - 1);
            rem     <= '0;
            root    <= '0;
            drain   <= 1'b0;
            busy    <= 1'b1;
            state   <= CALC;
          end
        end
        CALC: begin
          if (!drain) begin
            rem  <= rem_next;
            root <= root_next;
            op   <= op << 2;
            if (counter == '0) begin
              drain <= 1'b1;
            end else begin
              counter <= counter - 1'b1;
            end
          end else begin
            drain     <= 1'b0;
            rsp_root  <= root;
            rsp_id    <= IDW'(id_q);
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_share_arbiter.sv
// tb_sqrt_share_arbiter
//   Directed self-checking bench for sqrt_share_arbiter at default parameters
//   (4 requesters, 29-bit operands, 15-bit roots). Inputs change and outputs
//   are sampled on the falling clock edge.

module tb_sqrt_share_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 29;
  localparam int RW   = 15;
  localparam int IDW  = 3;

  logic               clk;
  logic               reset;
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic               busy;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [RW-1:0]      rsp_root;

  int n_checks = 0;
  int n_fail   = 0;

  sqrt_share_arbiter #(.NREQ(NREQ), .DATA_W(DW), .IDW(IDW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_data  (req_data),
    .gnt       (gnt),
    .busy      (busy),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_root  (rsp_root)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] r, input logic rdy);
    req       = r;
    rsp_ready = rdy;
  endtask

  task automatic setData(input int k, input logic [31:0] val);
    req_data[k*DW +: DW] = val[DW-1:0];
  endtask

  // Bounded wait for rsp_valid; returns the number of falling edges waited.
  task automatic waitValid(output int edges);
    edges = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      edges++;
      if (rsp_valid) break;
    end
  endtask

  // Bounded wait for any grant pulse.
  task automatic waitGnt(output logic [NREQ-1:0] g);
    g = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (gnt != '0) begin
        g = gnt;
        break;
      end
    end
  endtask

  // Reference floor-sqrt by squaring candidates.
  function automatic logic [31:0] isqrt(input logic [31:0] v);
    longint r, t;
    r = 0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (longint'(1) << b);
      if (t * t <= longint'(v)) r = t;
    end
    return 32'(r);
  endfunction

  // Single requester, rsp_ready high: grant, exact latency, result, release.
  task automatic runSingle(input int k, input logic [31:0] data, input logic [31:0] exp_root, input string tag);
    int e;
    setData(k, data);
    applyStimulus(NREQ'(1 << k), 1'b1);
    @(negedge clk);
    checkOutput({tag, " gnt"}, 32'(gnt), 32'(1 << k));
    checkOutput({tag, " busy"}, 32'(busy), 32'd1);
    applyStimulus('0, 1'b1);
    @(negedge clk);
    checkOutput({tag, " gnt pulse"}, 32'(gnt), 32'd0);
    waitValid(e);
    checkOutput({tag, " latency"}, 32'(e + 1), 32'd16);
    checkOutput({tag, " root"}, 32'(rsp_root), exp_root);
    checkOutput({tag, " id"}, 32'(rsp_id), 32'(k));
    @(negedge clk);
    checkOutput({tag, " valid drop"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    logic [NREQ-1:0] g;
    logic [31:0]     d;
    logic [31:0]     exp_f [4];
    int              e;
    int              k;
    int              seen;

    exp_f[0] = 32'd4;
    exp_f[1] = 32'd9;
    exp_f[2] = 32'd12;
    exp_f[3] = 32'd100;

    reset     = 1'b1;
    req       = '0;
    req_data  = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    $display("[TB] reset state");
    checkOutput("rst gnt", 32'(gnt), 32'd0);
    checkOutput("rst busy", 32'(busy), 32'd0);
    checkOutput("rst valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst id", 32'(rsp_id), 32'd0);
    checkOutput("rst root", 32'(rsp_root), 32'd0);

    $display("[TB] single request");
    runSingle(0, 32'd1000000, 32'd1000, "single");

    $display("[TB] boundary operands");
    runSingle(2, 32'd0, 32'd0, "b0");
    runSingle(2, 32'd1, 32'd1, "b1");
    runSingle(2, 32'd3, 32'd1, "b3");
    runSingle(2, 32'd536870911, 32'd23170, "bmax");

    $display("[TB] fairness");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    setData(0, 32'd16);
    setData(1, 32'd81);
    setData(2, 32'd144);
    setData(3, 32'd10000);
    applyStimulus(4'b1111, 1'b1);
    for (int n = 0; n < 5; n++) begin
      waitGnt(g);
      checkOutput("rr gnt", 32'(g), 32'(1 << (n % 4)));
      if (n == 4) applyStimulus('0, 1'b1);
      waitValid(e);
      checkOutput("rr id", 32'(rsp_id), 32'(n % 4));
      checkOutput("rr root", 32'(rsp_root), exp_f[n % 4]);
    end
    @(negedge clk);
    checkOutput("rr end valid", 32'(rsp_valid), 32'd0);

    $display("[TB] backpressure");
    setData(1, 32'd49);
    applyStimulus(4'b0010, 1'b0);
    waitGnt(g);
    checkOutput("bp gnt", 32'(g), 32'b0010);
    setData(0, 32'd25);
    applyStimulus(4'b0001, 1'b0);
    waitValid(e);
    checkOutput("bp valid", 32'(rsp_valid), 32'd1);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      checkOutput("bp hold valid", 32'(rsp_valid), 32'd1);
      checkOutput("bp hold root", 32'(rsp_root), 32'd7);
      checkOutput("bp hold id", 32'(rsp_id), 32'd1);
      checkOutput("bp hold busy", 32'(busy), 32'd1);
      checkOutput("bp no gnt", 32'(gnt), 32'd0);
    end
    applyStimulus(4'b0001, 1'b1);
    @(negedge clk);
    checkOutput("bp hs valid", 32'(rsp_valid), 32'd0);
    checkOutput("bp idle busy", 32'(busy), 32'd0);
    checkOutput("bp idle gnt", 32'(gnt), 32'd0);
    @(negedge clk);
    checkOutput("bp next gnt", 32'(gnt), 32'b0001);
    applyStimulus('0, 1'b1);
    waitValid(e);
    checkOutput("bp next root", 32'(rsp_root), 32'd5);
    checkOutput("bp next id", 32'(rsp_id), 32'd0);
    @(negedge clk);

    $display("[TB] reset mid-operation");
    setData(3, 32'd10000);
    applyStimulus(4'b1000, 1'b1);
    @(negedge clk);
    checkOutput("mr gnt", 32'(gnt), 32'b1000);
    applyStimulus('0, 1'b1);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("mr gnt0", 32'(gnt), 32'd0);
    checkOutput("mr busy0", 32'(busy), 32'd0);
    checkOutput("mr valid0", 32'(rsp_valid), 32'd0);
    checkOutput("mr id0", 32'(rsp_id), 32'd0);
    checkOutput("mr root0", 32'(rsp_root), 32'd0);
    seen = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    checkOutput("mr no stale rsp", 32'(seen), 32'd0);
    setData(1, 32'd2);
    applyStimulus(4'b1010, 1'b1);
    waitGnt(g);
    checkOutput("mr first gnt", 32'(g), 32'b0010);
    applyStimulus(4'b1000, 1'b1);
    waitValid(e);
    checkOutput("mr r1 root", 32'(rsp_root), 32'd1);
    checkOutput("mr r1 id", 32'(rsp_id), 32'd1);
    waitGnt(g);
    checkOutput("mr second gnt", 32'(g), 32'b1000);
    applyStimulus('0, 1'b1);
    waitValid(e);
    checkOutput("mr r3 root", 32'(rsp_root), 32'd100);
    checkOutput("mr r3 id", 32'(rsp_id), 32'd3);
    @(negedge clk);

    $display("[TB] random operands");
    for (int n = 0; n < 20; n++) begin
      k = int'($urandom_range(0, NREQ - 1));
      d = $urandom & 32'h1FFF_FFFF;
      setData(k, d);
      applyStimulus(NREQ'(1 << k), 1'($urandom_range(0, 1)));
      waitGnt(g);
      checkOutput("rnd gnt", 32'(g), 32'(1 << k));
      applyStimulus('0, rsp_ready);
      waitValid(e);
      checkOutput("rnd root", 32'(rsp_root), isqrt(d));
      checkOutput("rnd id", 32'(rsp_id), 32'(k));
      for (int i = 0; i < 100; i++) begin
        if (!rsp_valid) break;
        rsp_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      checkOutput("rnd handshake", 32'(rsp_valid), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
